read_data_router: RTL

READ_DATA_ROUTER -- requirements
Module: read_data_router

---
 rtl/read_data_router_pkg.sv | 42 ++++
 rtl/read_data_router_burst_track_fifo.sv | 53 +++++
 rtl/read_data_router.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/read_data_router_pkg.sv
// Shared crossbar definitions for the R-channel return path.
// Master count, field widths, destination encoding and tracking entry.
package read_data_router_pkg;

  localparam int NUM_M = 3;
  localparam int ID_W  = 6;
  localparam int LEN_W = 8;
  localparam int DST_W = 2;

  typedef enum logic [DST_W-1:0] {
    DST_M0 = 2'd0,
    DST_M1 = 2'd1,
    DST_M2 = 2'd2
  } dst_t;

  typedef struct packed {
    dst_t             dst;
    logic [LEN_W-1:0] len;
  } track_t;

  localparam int TRACK_W = $bits(track_t);

  typedef enum logic {
    ST_IDLE,
    ST_BURST
  } rd_state_t;

  function automatic dst_t grant_to_dst(
    input logic [NUM_M-1:0] g
  );
    dst_t d;
    d = DST_M0;
    unique case (1'b1)
      g[0]:    d = DST_M0;
      g[1]:    d = DST_M1;
      g[2]:    d = DST_M2;
      default: d = DST_M0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/read_data_router_burst_track_fifo.sv
// Outstanding-burst tracking FIFO: {dst, arlen} per accepted AR.
// Pointers carry an extra wrap bit to tell full from empty.
module burst_track_fifo
  import read_data_router_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = TRACK_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;

  // a push into a full FIFO only lands when the head leaves this cycle
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign dout = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/read_data_router.sv
// Routes slave R beats to the master that issued the matching AR.
// One-entry holding stage; rlast regenerated from tracked arlen.
module read_data_router
  import read_data_router_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ar_fire,
  input  logic [NUM_M-1:0]  ar_grant,
  input  logic [LEN_W-1:0]  ar_arlen,
  output logic              ar_track_ready,
  input  logic [DATA_W-1:0] s_axi_rdata,
  input  logic [ID_W-1:0]   s_axi_rid,
  input  logic [1:0]        s_axi_rresp,
  input  logic              s_axi_rlast,
  input  logic              s_axi_rvalid,
  output logic              s_axi_rready,
  output logic [DATA_W-1:0] m_axi_rdata_m0,
  output logic [ID_W-1:0]   m_axi_rid_m0,
  output logic [1:0]        m_axi_rresp_m0,
  output logic              m_axi_rlast_m0,
  output logic              m_axi_rvalid_m0,
  input  logic              m_axi_rready_m0,
  output logic [DATA_W-1:0] m_axi_rdata_m1,
  output logic [ID_W-1:0]   m_axi_rid_m1,
  output logic [1:0]        m_axi_rresp_m1,
  output logic              m_axi_rlast_m1,
  output logic              m_axi_rvalid_m1,
  input  logic              m_axi_rready_m1,
  output logic [DATA_W-1:0] m_axi_rdata_m2,
  output logic [ID_W-1:0]   m_axi_rid_m2,
  output logic [1:0]        m_axi_rresp_m2,
  output logic              m_axi_rlast_m2,
  output logic              m_axi_rvalid_m2,
  input  logic              m_axi_rready_m2,
  output logic              rlast_err
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  rd_state_t         state;
  logic [LEN_W-1:0]  beat_cnt;
  track_t            head;
  track_t            push_entry;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_cnt;
  logic              push_ok;
  logic              pop;
  logic              fifo_drains;
  logic              s_fire;
  logic              beat_last;
  logic              sel_ready;

  logic              hold_valid;
  dst_t              hold_dst;
  logic [DATA_W-1:0] hold_data;
  logic [ID_W-1:0]   hold_id;
  logic [1:0]        hold_resp;
  logic              hold_last;

  assign push_entry = '{dst: grant_to_dst(ar_grant), len: ar_arlen};

  assign beat_last   = (beat_cnt == head.len);
  assign s_fire      = s_axi_rvalid && s_axi_rready;
  assign pop         = s_fire && beat_last;
  assign push_ok     = ar_fire && (!fifo_full || pop);
  assign fifo_drains = (fifo_cnt == CNT_W'(1)) && !push_ok;

  burst_track_fifo #(
    .DEPTH (DEPTH),
    .W     (TRACK_W)
  ) u_track (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_ok),
    .din   (push_entry),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  assign ar_track_ready = !fifo_full;

  always_comb begin
    sel_ready = 1'b0;
    unique case (hold_dst)
      DST_M0:  sel_ready = m_axi_rready_m0;
      DST_M1:  sel_ready = m_axi_rready_m1;
      DST_M2:  sel_ready = m_axi_rready_m2;
      default: sel_ready = 1'b0;
    endcase
  end

  assign s_axi_rready = (state == ST_BURST) &&
                        (!hold_valid || sel_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      beat_cnt <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          beat_cnt <= '0;
          if (!fifo_empty) state <= ST_BURST;
        end
        ST_BURST: begin
          if (s_fire) begin
            if (beat_last) begin
              beat_cnt <= '0;
              if (fifo_drains) state <= ST_IDLE;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
      endcase
    end
  end

  // load wins over drain so a stream keeps one beat per cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid <= 1'b0;
      hold_dst   <= DST_M0;
      hold_data  <= '0;
      hold_id    <= '0;
      hold_resp  <= '0;
      hold_last  <= 1'b0;
      rlast_err  <= 1'b0;
    end else begin
      if (s_fire) begin
        hold_valid <= 1'b1;
        hold_dst   <= head.dst;
        hold_data  <= s_axi_rdata;
        hold_id    <= s_axi_rid;
        hold_resp  <= s_axi_rresp;
        hold_last  <= beat_last;
      end else if (sel_ready) begin
        hold_valid <= 1'b0;
      end
      if (s_fire && (s_axi_rlast != beat_last)) rlast_err <= 1'b1;
    end
  end

  assign m_axi_rvalid_m0 = hold_valid && (hold_dst == DST_M0);
  assign m_axi_rvalid_m1 = hold_valid && (hold_dst == DST_M1);
  assign m_axi_rvalid_m2 = hold_valid && (hold_dst == DST_M2);

  assign m_axi_rdata_m0 = hold_data;
  assign m_axi_rdata_m1 = hold_data;
  assign m_axi_rdata_m2 = hold_data;
  assign m_axi_rid_m0   = hold_id;
  assign m_axi_rid_m1   = hold_id;
  assign m_axi_rid_m2   = hold_id;
  assign m_axi_rresp_m0 = hold_resp;
  assign m_axi_rresp_m1 = hold_resp;
  assign m_axi_rresp_m2 = hold_resp;
  assign m_axi_rlast_m0 = hold_last;
  assign m_axi_rlast_m1 = hold_last;
  assign m_axi_rlast_m2 = hold_last;

endmodule
